// File: rtl/frame_cfg_pkg.sv
// Shared types and constants for the frame configuration sequencer:
// FSM state enum, header field layout, and the CRC-16-CCITT word update.
package frame_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_CRC    = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Header word layout: {SYNC, column, frame count, reserved}
  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_COL_LSB  = 16;
  localparam int HDR_NFR_LSB  = 8;
  localparam int HDR_RSV_LSB  = 0;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Fold one 32-bit word into the CRC, MSB first.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                             input logic [31:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_config_sequencer_if.sv
// 32-bit valid/ready word stream from the bitstream port.
interface frame_config_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/frame_cfg_crc16.sv
// CRC-16-CCITT accumulator, one 32-bit word per cycle.
// clr_i restarts from CRC_INIT; with en_i in the same cycle the word is
// folded into the fresh seed, so a header can start the run directly.
module frame_cfg_crc16
  import frame_cfg_pkg::*;
(
  input  logic        CLK,
  input  logic        resetn,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d, base;

  // Next CRC: optional restart, then optional word update.
  always_comb begin
    base  = clr_i ? CRC_INIT : crc_q;
    crc_d = en_i ? crc16_word(base, data_i) : base;
  end

  // CRC register.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) crc_q <= CRC_INIT;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/frame_config_sequencer.sv
// Column configuration loader: decodes a header word, then for each data
// word runs SETUP (FrameData valid) -> STROBE (one-hot FrameStrobe[k]) ->
// HOLD (data held) before taking the next word.
// Optional feature macro: CFG_CRC_EN adds a CRC-16 trailer word check.
module frame_config_sequencer
  import frame_cfg_pkg::*;
#(
  parameter int FRAME_BITS  = 32,
  parameter int MAX_FRAMES  = 20,
  parameter int NUM_COLUMNS = 60,
  parameter int COL_W       = 6
)(
  input  logic                  CLK,
  input  logic                  resetn,
  frame_config_sequencer_if.slave s,
  output logic [COL_W-1:0]      col_sel,
  output logic [FRAME_BITS-1:0] FrameData,
  output logic [MAX_FRAMES-1:0] FrameStrobe,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [7:0] NCOL8 = 8'(NUM_COLUMNS);
  localparam logic [7:0] MAXF8 = 8'(MAX_FRAMES);

  state_e                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic [7:0]            nfr_q, nfr_d;
  logic [7:0]            k_q, k_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [7:0] hdr_sync, hdr_col, hdr_nfr, hdr_rsv;
  logic       hdr_ok;
  logic       last_frame;

  // Header field decode and acceptance test.
  always_comb begin
    hdr_sync = s.s_data[HDR_SYNC_LSB +: 8];
    hdr_col  = s.s_data[HDR_COL_LSB  +: 8];
    hdr_nfr  = s.s_data[HDR_NFR_LSB  +: 8];
    hdr_rsv  = s.s_data[HDR_RSV_LSB  +: 8];
    hdr_ok   = (hdr_sync == SYNC_BYTE) && (hdr_col < NCOL8) &&
               (hdr_nfr != 8'd0) && (hdr_nfr <= MAXF8) && (hdr_rsv == 8'd0);
  end

  assign last_frame = (8'(k_q + 8'd1) == nfr_q);

`ifdef CFG_CRC_EN
  logic        crc_clr, crc_en;
  logic [15:0] crc_val;

  frame_cfg_crc16 u_crc (
    .CLK    (CLK),
    .resetn (resetn),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .data_i (s.s_data),
    .crc_o  (crc_val)
  );
`endif

  // Next-state and register updates; done is a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    data_d  = data_q;
    nfr_d   = nfr_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef CFG_CRC_EN
    crc_clr = 1'b0;
    crc_en  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (s.s_valid) begin
          if (hdr_ok) begin
            col_d   = hdr_col[COL_W-1:0];
            nfr_d   = hdr_nfr;
            k_d     = 8'd0;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            state_d = S_DATA;
`ifdef CFG_CRC_EN
            crc_clr = 1'b1;
            crc_en  = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (s.s_valid) begin
          data_d  = s.s_data[FRAME_BITS-1:0];
          state_d = S_SETUP;
`ifdef CFG_CRC_EN
          crc_en  = 1'b1;
`endif
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
        k_d = 8'(k_q + 8'd1);
        if (last_frame) begin
`ifdef CFG_CRC_EN
          state_d = S_CRC;
`else
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef CFG_CRC_EN
      S_CRC: begin
        if (s.s_valid) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (s.s_data[15:0] == crc_val) done_d = 1'b1;
          else                           err_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any load in progress.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      data_q  <= '0;
      nfr_q   <= 8'd0;
      k_q     <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      data_q  <= data_d;
      nfr_q   <= nfr_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Strobe decode straight from registered state, so reset kills it at once.
  for (genvar i = 0; i < MAX_FRAMES; i++) begin : g_stb
    assign FrameStrobe[i] = (state_q == S_STROBE) && (k_q == 8'(i));
  end

  assign s.s_ready = (state_q == S_IDLE) || (state_q == S_DATA) ||
                     (state_q == S_CRC);
  assign col_sel   = col_q;
  assign FrameData = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed bench for frame_config_sequencer: header decode, strobe timing,
// rejected headers, stalls, boundaries, mid-load reset and (CFG_CRC_EN) CRC.
module tb_frame_config_sequencer;

  logic        CLK = 1'b0;
  logic        resetn;
  logic [5:0]  col_sel;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        busy, done, error;

  frame_config_sequencer_if sif ();

  frame_config_sequencer dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .s           (sif),
    .col_sel     (col_sel),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [19:0] ev_stb [128];
  logic [31:0] ev_data [128];
  logic [31:0] ev_dnext [128];
  int          ev_cyc [128];
  int          ev_n = 0;
  bit          pend = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          busy_fall = 0;
  bit          prev_busy = 0;
  int          acc [32];
  logic [31:0] wds [32];
  bit          to_err = 0;
  int          last_acc = 0;
`ifdef CFG_CRC_EN
  bit          flip_crc = 0;

  function automatic logic [15:0] tb_crc(input logic [15:0] c, input logic [31:0] w);
    logic [15:0] r;
    logic        b;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      b = r[15] ^ w[i];
      r = r << 1;
      if (b) r = r ^ 16'h1021;
    end
    return r;
  endfunction
`endif

  always @(posedge CLK) cyc <= cyc + 1;

  // Observe strobes, data one cycle after each strobe, done pulses, busy falls.
  always @(negedge CLK) begin
    if (pend) begin
      ev_dnext[ev_n-1] = FrameData;
      pend = 0;
    end
    if (FrameStrobe != 20'h0 && ev_n < 128) begin
      ev_stb[ev_n]  = FrameStrobe;
      ev_data[ev_n] = FrameData;
      ev_cyc[ev_n]  = cyc;
      ev_n++;
      pend = 1;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_busy && !busy) busy_fall++;
    prev_busy = busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one word after gap idle cycles; returns at the negedge after accept.
  task automatic send(input logic [31:0] w, input int gap);
    int n;
    repeat (gap) @(negedge CLK);
    sif.s_valid = 1'b1;
    sif.s_data  = w;
    n = 0;
    while (sif.s_ready !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      to_err = 1;
      sif.s_valid = 1'b0;
    end else begin
      @(posedge CLK);
      @(negedge CLK);
      last_acc = cyc;
      sif.s_valid = 1'b0;
    end
  endtask

  // Header + n data words (+ CRC trailer when enabled).
  task automatic load(input logic [7:0] col, input int n, input int gap);
    logic [31:0] h;
`ifdef CFG_CRC_EN
    logic [15:0] c;
`endif
    h = {8'hA5, col, 8'(n), 8'h00};
    send(h, 0);
`ifdef CFG_CRC_EN
    c = tb_crc(16'hFFFF, h);
`endif
    for (int i = 0; i < n; i++) begin
      wds[i] = {8'(i) + 8'h10, col, 16'hBEEF ^ 16'(i)};
      send(wds[i], gap);
      acc[i] = last_acc;
`ifdef CFG_CRC_EN
      c = tb_crc(c, wds[i]);
`endif
    end
`ifdef CFG_CRC_EN
    send({16'h0000, c ^ {15'h0, flip_crc}}, 0);
`endif
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data = 32'h0;
    repeat (3) @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    checks++; if (sif.s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", sif.s_ready); end
    checks++; if (FrameStrobe !== 20'h0) begin failures++; $display("FAIL reset_strobe: got %h want 0", FrameStrobe); end
    checks++; if (FrameData !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", FrameData); end
    checks++; if (col_sel !== 6'd0) begin failures++; $display("FAIL reset_col: got %0d want 0", col_sel); end
    checks++; if ({busy, done, error} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {busy, done, error}); end
  endtask

  task automatic test_basic();
    int b, d;
    b = ev_n; d = done_cnt;
    load(8'd5, 3, 0);
    checks++; if (to_err !== 1'b0) begin failures++; $display("FAIL basic_timeout: got %b want 0", to_err); end
    checks++; if (col_sel !== 6'd5) begin failures++; $display("FAIL basic_col: got %0d want 5", col_sel); end
    checks++; if (ev_n - b !== 3) begin failures++; $display("FAIL basic_nstrobe: got %0d want 3", ev_n - b); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (ev_stb[b+i] !== 20'(1 << i)) begin failures++; $display("FAIL basic_stb%0d: got %h want %h", i, ev_stb[b+i], 20'(1 << i)); end
      checks++; if (ev_cyc[b+i] !== acc[i] + 1) begin failures++; $display("FAIL basic_stbcyc%0d: got %0d want %0d", i, ev_cyc[b+i], acc[i] + 1); end
      checks++; if (ev_data[b+i] !== wds[i]) begin failures++; $display("FAIL basic_data%0d: got %h want %h", i, ev_data[b+i], wds[i]); end
      checks++; if (ev_dnext[b+i] !== wds[i]) begin failures++; $display("FAIL basic_hold%0d: got %h want %h", i, ev_dnext[b+i], wds[i]); end
    end
    checks++; if (done_cnt - d !== 1) begin failures++; $display("FAIL basic_done: got %0d want 1", done_cnt - d); end
`ifndef CFG_CRC_EN
    checks++; if (done_cyc !== acc[2] + 3) begin failures++; $display("FAIL basic_donecyc: got %0d want %0d", done_cyc, acc[2] + 3); end
`endif
    checks++; if ({busy, error} !== 2'b00) begin failures++; $display("FAIL basic_idle: got %b want 00", {busy, error}); end
    checks++; if (FrameData !== wds[2]) begin failures++; $display("FAIL basic_dataheld: got %h want %h", FrameData, wds[2]); end
  endtask

  task automatic test_bad_headers();
    logic [31:0] bh [5];
    logic [5:0]  exp_col;
    int b, d;
    bh[0] = 32'h5A050300; bh[1] = 32'hA53C0300; bh[2] = 32'hA5050000;
    bh[3] = 32'hA5051500; bh[4] = 32'hA5050301;
    exp_col = 6'd5;
    for (int i = 0; i < 5; i++) begin
      b = ev_n; d = done_cnt;
      send(bh[i], 0);
      repeat (4) @(negedge CLK);
      checks++; if (error !== 1'b1) begin failures++; $display("FAIL bad%0d_error: got %b want 1", i, error); end
      checks++; if (sif.s_ready !== 1'b1) begin failures++; $display("FAIL bad%0d_ready: got %b want 1", i, sif.s_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bad%0d_busy: got %b want 0", i, busy); end
      checks++; if (ev_n !== b) begin failures++; $display("FAIL bad%0d_strobe: got %0d want %0d", i, ev_n, b); end
      checks++; if (col_sel !== exp_col) begin failures++; $display("FAIL bad%0d_col: got %0d want %0d", i, col_sel, exp_col); end
      // a good load must clear the sticky error and complete
      load(8'd7, 1, 0);
      exp_col = 6'd7;
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL recover%0d_error: got %b want 0", i, error); end
      checks++; if (ev_n - b !== 1) begin failures++; $display("FAIL recover%0d_strobe: got %0d want 1", i, ev_n - b); end
      checks++; if (done_cnt - d !== 1) begin failures++; $display("FAIL recover%0d_done: got %0d want 1", i, done_cnt - d); end
    end
  endtask

  task automatic test_gaps();
    int b, d, f;
    b = ev_n; d = done_cnt; f = busy_fall;
    load(8'd9, 2, 7);
    checks++; if (ev_n - b !== 2) begin failures++; $display("FAIL gap_nstrobe: got %0d want 2", ev_n - b); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (ev_cyc[b+i] !== acc[i] + 1) begin failures++; $display("FAIL gap_stbcyc%0d: got %0d want %0d", i, ev_cyc[b+i], acc[i] + 1); end
      checks++; if (ev_stb[b+i] !== 20'(1 << i)) begin failures++; $display("FAIL gap_stb%0d: got %h want %h", i, ev_stb[b+i], 20'(1 << i)); end
    end
    checks++; if (busy_fall - f !== 1) begin failures++; $display("FAIL gap_busy: got %0d falls want 1", busy_fall - f); end
    checks++; if (done_cnt - d !== 1) begin failures++; $display("FAIL gap_done: got %0d want 1", done_cnt - d); end
`ifndef CFG_CRC_EN
    checks++; if (done_cyc !== acc[1] + 3) begin failures++; $display("FAIL gap_donecyc: got %0d want %0d", done_cyc, acc[1] + 3); end
`endif
  endtask

  task automatic test_boundary();
    int b, d;
    b = ev_n; d = done_cnt;
    load(8'd59, 20, 0);
    checks++; if (col_sel !== 6'd59) begin failures++; $display("FAIL bnd_col: got %0d want 59", col_sel); end
    checks++; if (ev_n - b !== 20) begin failures++; $display("FAIL bnd_nstrobe: got %0d want 20", ev_n - b); end
    checks++; if (ev_stb[b+19] !== 20'h80000) begin failures++; $display("FAIL bnd_last: got %h want 80000", ev_stb[b+19]); end
    checks++; if (ev_data[b+19] !== wds[19]) begin failures++; $display("FAIL bnd_data: got %h want %h", ev_data[b+19], wds[19]); end
    checks++; if (done_cnt - d !== 1 || error !== 1'b0) begin failures++; $display("FAIL bnd_done: got %0d/%b want 1/0", done_cnt - d, error); end
  endtask

`ifdef CFG_CRC_EN
  task automatic test_crc();
    int b, d;
    flip_crc = 0;
    d = done_cnt;
    load(8'd3, 1, 0);
    checks++; if (done_cnt - d !== 1 || error !== 1'b0) begin failures++; $display("FAIL crc_good: got %0d/%b want 1/0", done_cnt - d, error); end
    flip_crc = 1;
    b = ev_n; d = done_cnt;
    load(8'd3, 1, 0);
    checks++; if (done_cnt - d !== 0) begin failures++; $display("FAIL crc_bad_done: got %0d want 0", done_cnt - d); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL crc_bad_error: got %b want 1", error); end
    checks++; if (ev_n - b !== 1) begin failures++; $display("FAIL crc_bad_strobe: got %0d want 1", ev_n - b); end
    flip_crc = 0;
    load(8'd4, 2, 0);
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL crc_recover: got %b want 0", error); end
  endtask
`endif

  task automatic test_reset_mid();
    int b, d;
    send(32'hA5040300, 0);
    send(32'h0BADF00D, 0);
    send(32'h12345678, 0);
    @(negedge CLK);
    checks++; if (FrameStrobe !== 20'h2) begin failures++; $display("FAIL rst_pre_strobe: got %h want 00002", FrameStrobe); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (FrameStrobe !== 20'h0) begin failures++; $display("FAIL rst_strobe: got %h want 0", FrameStrobe); end
    checks++; if (sif.s_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rst_state: got ready=%b busy=%b want 1/0", sif.s_ready, busy); end
    @(negedge CLK);
    resetn = 1'b1;
    b = ev_n; d = done_cnt;
    repeat (10) @(negedge CLK);
    checks++; if (ev_n !== b) begin failures++; $display("FAIL rst_nostrobe: got %0d want %0d", ev_n, b); end
    checks++; if (done_cnt !== d) begin failures++; $display("FAIL rst_nodone: got %0d want %0d", done_cnt, d); end
    checks++; if (sif.s_ready !== 1'b1 || col_sel !== 6'd0) begin failures++; $display("FAIL rst_idle: got ready=%b col=%0d want 1/0", sif.s_ready, col_sel); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_headers();
    test_gaps();
    test_boundary();
`ifdef CFG_CRC_EN
    test_crc();
`endif
    test_reset_mid();
    checks++; if (to_err !== 1'b0) begin failures++; $display("FAIL handshake_timeout: got %b want 0", to_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
